// File: rtl/conv_mult_scheduler_if.sv
// Job-issue handshake and multiplier-pool status shared by the conv
// scheduler (master) and the multiplier datapath (slave).
interface conv_mult_scheduler_if #(
    parameter int NMULT = 64,
    parameter int MW    = 6,
    parameter int OW    = 5,
    parameter int FW    = 3
);
    logic [NMULT-1:0] mult_busy_i;
    logic [NMULT-1:0] cmpl_i;
    logic             issue_valid_o;
    logic             issue_ready_i;
    logic [MW-1:0]    issue_mult_o;
    logic [OW-1:0]    issue_row_o;
    logic [OW-1:0]    issue_col_o;
    logic [FW-1:0]    issue_filt_o;

    modport master (
        input  mult_busy_i,
        input  cmpl_i,
        input  issue_ready_i,
        output issue_valid_o,
        output issue_mult_o,
        output issue_row_o,
        output issue_col_o,
        output issue_filt_o
    );

    modport slave (
        output mult_busy_i,
        output cmpl_i,
        output issue_ready_i,
        input  issue_valid_o,
        input  issue_mult_o,
        input  issue_row_o,
        input  issue_col_o,
        input  issue_filt_o
    );
endinterface

// File: rtl/conv_mult_scheduler.sv
// Walks (col,row,filt) of a conv layer and issues each pixel to a free pool multiplier.
// Optional CONV_SCHED_STALL_STATS_EN adds stall_cnt_o (saturating stall-cycle counter).
module conv_mult_scheduler #(
    parameter int IMG_N  = 32,
    parameter int FLT_F  = 3,
    parameter int PAD    = 1,
    parameter int STRIDE = 1,
    parameter int NFILT  = 8,
    parameter int NMULT  = 64,
    parameter int MW     = (NMULT > 1) ? $clog2(NMULT) : 1,
    parameter int OW     = (((IMG_N - FLT_F + 2*PAD) / STRIDE + 1) > 1) ?
                           $clog2((IMG_N - FLT_F + 2*PAD) / STRIDE + 1) : 1,
    parameter int FW     = (NFILT > 1) ? $clog2(NFILT) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic                 abort_i,
    conv_mult_scheduler_if.master bus,
    output logic [MW:0]          outstanding_o,
    output logic                 busy_o,
    output logic                 done_o
`ifdef CONV_SCHED_STALL_STATS_EN
    ,
    output logic [31:0]          stall_cnt_o
`endif
);
    localparam int OUT_N = (IMG_N - FLT_F + 2*PAD) / STRIDE + 1;
    localparam logic [OW-1:0] OUT_LAST  = OW'(OUT_N - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(NFILT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic             valid_q;
    logic [MW-1:0]    mult_q;
    logic [OW-1:0]    row_q;
    logic [OW-1:0]    col_q;
    logic [FW-1:0]    filt_q;
    logic [NMULT-1:0] claimed;
    logic [NMULT-1:0] claimed_nx;
    logic [NMULT-1:0] elig;
    logic [NMULT-1:0] grant;
    logic [MW-1:0]    sel;
    logic             any_elig;
    logic             hs;
    logic             last;
    logic [MW:0]      pop_nx;

    assign elig  = ~bus.mult_busy_i & ~claimed;
    assign grant = NMULT'(1) << mult_q;
    assign hs    = valid_q & bus.issue_ready_i;
    assign last  = (col_q == OUT_LAST) && (row_q == OUT_LAST) &&
                   (filt_q == FILT_LAST);

    // Scan downward so the lowest eligible index is the one left in sel.
    always_comb begin
        sel      = '0;
        any_elig = 1'b0;
        for (int m = NMULT - 1; m >= 0; m--) begin
            if (elig[m]) begin
                sel      = MW'(m);
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin
        claimed_nx = claimed & ~bus.cmpl_i;
        if (hs)
            claimed_nx = claimed_nx | grant;
        pop_nx = '0;
        for (int m = 0; m < NMULT; m++)
            pop_nx = pop_nx + (MW+1)'(claimed_nx[m]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            valid_q       <= 1'b0;
            mult_q        <= '0;
            row_q         <= '0;
            col_q         <= '0;
            filt_q        <= '0;
            claimed       <= '0;
            outstanding_o <= '0;
        end else if (abort_i) begin
            state         <= S_IDLE;
            valid_q       <= 1'b0;
            claimed       <= '0;
            outstanding_o <= '0;
        end else begin
            claimed       <= claimed_nx;
            outstanding_o <= pop_nx;
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state   <= S_ISSUE;
                        valid_q <= 1'b0;
                        row_q   <= '0;
                        col_q   <= '0;
                        filt_q  <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!valid_q) begin
                        if (any_elig) begin
                            valid_q <= 1'b1;
                            mult_q  <= sel;
                        end
                    end else if (bus.issue_ready_i) begin
                        valid_q <= 1'b0;
                        if (last) begin
                            state  <= S_DRAIN;
                            col_q  <= '0;
                            row_q  <= '0;
                            filt_q <= '0;
                        end else if (col_q != OUT_LAST) begin
                            col_q <= col_q + 1'b1;
                        end else begin
                            col_q <= '0;
                            if (row_q != OUT_LAST) begin
                                row_q <= row_q + 1'b1;
                            end else begin
                                row_q  <= '0;
                                filt_q <= filt_q + 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (claimed == '0)
                        state <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CONV_SCHED_STALL_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_o <= '0;
        end else if (state == S_IDLE) begin
            if (start_i && !abort_i)
                stall_cnt_o <= '0;
        end else if (state == S_ISSUE && !valid_q && !any_elig &&
                     !abort_i && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

    assign bus.issue_valid_o = valid_q;
    assign bus.issue_mult_o  = mult_q;
    assign bus.issue_row_o   = row_q;
    assign bus.issue_col_o   = col_q;
    assign bus.issue_filt_o  = filt_q;
    assign busy_o            = (state != S_IDLE);
    assign done_o            = (state == S_DONE);
endmodule

// File: tb/tb_conv_mult_scheduler.sv
// Directed bench for conv_mult_scheduler: 4x4 output, 2 filters, 8-unit pool.
`timescale 1ns/1ps
module tb_conv_mult_scheduler;
    localparam int IMG_N  = 4;
    localparam int FLT_F  = 3;
    localparam int PAD    = 1;
    localparam int STRIDE = 1;
    localparam int NFILT  = 2;
    localparam int NMULT  = 8;
    localparam int MW     = 3;
    localparam int OW     = 2;
    localparam int FW     = 1;
    localparam int TOTAL  = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [MW:0] outstanding_o;
    logic        busy_o;
    logic        done_o;
`ifdef CONV_SCHED_STALL_STATS_EN
    logic [31:0] stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    conv_mult_scheduler_if #(.NMULT(NMULT), .MW(MW), .OW(OW), .FW(FW)) bus ();

    conv_mult_scheduler #(
        .IMG_N(IMG_N), .FLT_F(FLT_F), .PAD(PAD), .STRIDE(STRIDE),
        .NFILT(NFILT), .NMULT(NMULT)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start_i(start_i),
        .abort_i(abort_i),
        .bus(bus),
        .outstanding_o(outstanding_o),
        .busy_o(busy_o),
        .done_o(done_o)
`ifdef CONV_SCHED_STALL_STATS_EN
        ,
        .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] desc();
        return {bus.issue_filt_o, bus.issue_row_o, bus.issue_col_o};
    endfunction

    // Start a layer with a free pool; completions return 3 cycles after each handshake.
    task automatic run_jobs(input int stop_after, input bit inject,
                            output int hs, output int dones);
        int cnt [NMULT];
        int tail;
        hs    = 0;
        dones = 0;
        tail  = -1;
        for (int m = 0; m < NMULT; m++) cnt[m] = 0;
        bus.mult_busy_i   = '0;
        bus.issue_ready_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (stop_after > 0 && hs >= stop_after) break;
            if (tail == 0) break;
            bus.cmpl_i = '0;
            start_i    = 1'b0;
            for (int m = 0; m < NMULT; m++) begin
                if (cnt[m] > 0) begin
                    cnt[m]--;
                    if (cnt[m] == 0) bus.cmpl_i[m] = 1'b1;
                end
            end
            if (inject && hs == 5) begin
                start_i = 1'b1;
                if (cnt[5] == 0) bus.cmpl_i[5] = 1'b1;
            end
            if (done_o) begin
                dones++;
                if (tail < 0) tail = 3;
            end
            if (tail > 0) tail--;
            if (bus.issue_valid_o && bus.issue_ready_i) begin
                check("order", 32'(desc()), 32'(hs));
                check("mult_free", 32'(cnt[bus.issue_mult_o]), 32'd0);
                cnt[bus.issue_mult_o] = 3;
                hs++;
            end
            tick();
        end
        bus.cmpl_i = '0;
        start_i    = 1'b0;
    endtask

    initial begin
        int hs;
        int dn;
        int stalls;
        int dsum;
        bit saw;
        logic [7:0] pat [5];
        pat = '{8'hFF, 8'h00, 8'hA5, 8'h01, 8'hFE};

        bus.mult_busy_i   = '0;
        bus.cmpl_i        = '0;
        bus.issue_ready_i = 1'b0;
        #12;
        check("rst_outputs",
              32'({busy_o, done_o, bus.issue_valid_o, bus.issue_mult_o,
                   desc(), outstanding_o}), 32'd0);
`ifdef CONV_SCHED_STALL_STATS_EN
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
`endif
        rstn = 1'b1;
        tick();

        // Full layer, free pool
        run_jobs(0, 1'b0, hs, dn);
        check("s1_jobs", 32'(hs), 32'(TOTAL));
        check("s1_done_pulses", 32'(dn), 32'd1);
        check("s1_outstanding", 32'(outstanding_o), 32'd0);
        check("s1_idle", 32'(busy_o), 32'd0);

        // Only mult 0 free, completion withheld
        bus.mult_busy_i   = 8'hFE;
        bus.issue_ready_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        stalls = 0;
        for (int k = 0; k < 10 && !bus.issue_valid_o; k++) tick();
        check("s2_first_valid", 32'(bus.issue_valid_o), 32'd1);
        check("s2_first_mult", 32'(bus.issue_mult_o), 32'd0);
        check("s2_first_desc", 32'(desc()), 32'd0);
        tick();
        saw = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.issue_valid_o) saw = 1'b1;
            if (!bus.issue_valid_o && outstanding_o == 4'd1) stalls++;
            tick();
        end
        check("s2_stalled_low", 32'(saw), 32'd0);
        check("s2_outstanding1", 32'(outstanding_o), 32'd1);
        if (!bus.issue_valid_o && outstanding_o == 4'd1) stalls++;
        bus.cmpl_i = 8'h01;
        tick();
        bus.cmpl_i = '0;
        check("s2_released", 32'(outstanding_o), 32'd0);
        for (int k = 0; k < 10 && !bus.issue_valid_o; k++) tick();
        check("s2_reissue_valid", 32'(bus.issue_valid_o), 32'd1);
        check("s2_reissue_mult", 32'(bus.issue_mult_o), 32'd0);
        check("s2_reissue_desc", 32'(desc()), 32'd1);
`ifdef CONV_SCHED_STALL_STATS_EN
        check("s6_stall_cnt", stall_cnt_o, 32'(stalls));
`endif
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        tick();
`ifdef CONV_SCHED_STALL_STATS_EN
        check("s6_hold_idle", stall_cnt_o, 32'(stalls));
`endif

        // Ready held low while pool status toggles
        bus.mult_busy_i   = '0;
        bus.issue_ready_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
`ifdef CONV_SCHED_STALL_STATS_EN
        check("s6_clear_on_start", stall_cnt_o, 32'd0);
`endif
        for (int k = 0; k < 10 && !bus.issue_valid_o; k++) tick();
        for (int i = 0; i < 5; i++) begin
            check("s3_hold",
                  32'({bus.issue_valid_o, bus.issue_mult_o, desc()}), 32'h100);
            bus.mult_busy_i = pat[i];
            tick();
        end
        bus.issue_ready_i = 1'b1;
        check("s3_hold_ready",
              32'({bus.issue_valid_o, bus.issue_mult_o, desc()}), 32'h100);
        tick();
        bus.issue_ready_i = 1'b0;
        check("s3_one_handshake", 32'(outstanding_o), 32'd1);
        check("s3_valid_drop", 32'(bus.issue_valid_o), 32'd0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        bus.mult_busy_i = '0;
        tick();

        // Abort mid-layer
        run_jobs(10, 1'b0, hs, dn);
        check("s4_hs10", 32'(hs), 32'd10);
        abort_i = 1'b1;
        bus.cmpl_i = '0;
        tick();
        abort_i = 1'b0;
        check("s4_abort_state",
              32'({busy_o, bus.issue_valid_o, done_o, outstanding_o}), 32'd0);
        dsum = dn;
        for (int k = 0; k < 3; k++) begin
            if (done_o) dsum++;
            tick();
        end
        check("s4_no_done", 32'(dsum), 32'd0);

        // Restart from (0,0,0) with spurious completion and start pulses
        run_jobs(0, 1'b1, hs, dn);
        check("s5_jobs", 32'(hs), 32'(TOTAL));
        check("s5_done_pulses", 32'(dn), 32'd1);
        check("s5_outstanding", 32'(outstanding_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
